regfile_tagged: RTL

- Parametrised successor to the architectural integer register file, for the out-of-order core.
- Stores register values plus a per-register busy bit and producer tag (ROB index).
- Issue renames destinations; commit writes back values; flush drops all pending renames.
- Sits between decode/issue (read, rename) and the commit stage (write-back).

---
 rtl/regfile_tagged_pkg.sv | 14 +
 rtl/regfile_tagged_rport.sv | 41 ++++
 rtl/regfile_tagged.sv | 95 +++++++++
 3 files changed

// File: rtl/regfile_tagged_pkg.sv
// Shared sizing for the tagged register file, the ROB and the issue stage.
package regfile_tagged_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned TAGW = 4;
  localparam int unsigned NRD  = 2;

  typedef logic [XLEN-1:0] reg_bus_t;
  typedef logic [AW-1:0]   reg_addr_bus_t;
  typedef logic [TAGW-1:0] tag_bus_t;

endpackage

// File: rtl/regfile_tagged_rport.sv
// One read port: zero-latency value read with commit bypass, plus busy/tag
// status as it stands after this cycle's commit clear.
module regfile_tagged_rport #(
  parameter int unsigned XLEN = regfile_tagged_pkg::XLEN,
  parameter int unsigned NREG = regfile_tagged_pkg::NREG,
  parameter int unsigned AW   = regfile_tagged_pkg::AW,
  parameter int unsigned TAGW = regfile_tagged_pkg::TAGW
) (
  input  logic                       rst,
  input  logic                       en,
  input  logic [AW-1:0]              addr,
  input  logic [NREG-1:0][XLEN-1:0]  vals,
  input  logic [NREG-1:0]            busy_vec,
  input  logic [NREG-1:0][TAGW-1:0]  tag_vec,
  input  logic                       cmt_we,
  input  logic [AW-1:0]              cmt_addr,
  input  logic [XLEN-1:0]            cmt_data,
  input  logic [TAGW-1:0]            cmt_tag,
  output logic [XLEN-1:0]            data,
  output logic                       busy,
  output logic [TAGW-1:0]            tag
);

  import regfile_tagged_pkg::*;

  logic cmt_match;

  // Port output: zero when disabled, in reset or reading x0; otherwise bypassed read
  always_comb begin
    data      = '0;
    busy      = 1'b0;
    tag       = '0;
    cmt_match = cmt_we && (cmt_addr == addr);
    if (rst && en && (addr != '0)) begin
      data = cmt_match ? cmt_data : vals[addr];
      tag  = tag_vec[addr];
      busy = busy_vec[addr] && !(cmt_match && (tag_vec[addr] == cmt_tag));
    end
  end

endmodule

// File: rtl/regfile_tagged.sv
// Architectural register file with per-register busy bit and producer tag.
// Issue renames, commit writes back, flush drops all pending renames.
module regfile_tagged #(
  parameter int unsigned XLEN = regfile_tagged_pkg::XLEN,
  parameter int unsigned NREG = regfile_tagged_pkg::NREG,
  parameter int unsigned AW   = regfile_tagged_pkg::AW,
  parameter int unsigned NRD  = regfile_tagged_pkg::NRD,
  parameter int unsigned TAGW = regfile_tagged_pkg::TAGW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_we,
  input  logic [AW-1:0]        iss_addr,
  input  logic [TAGW-1:0]      iss_tag,
  input  logic                 cmt_we,
  input  logic [AW-1:0]        cmt_addr,
  input  logic [XLEN-1:0]      cmt_data,
  input  logic [TAGW-1:0]      cmt_tag,
  input  logic                 flush,
  input  logic [NRD-1:0]       re,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  output logic [NRD*TAGW-1:0]  rtag
);

  import regfile_tagged_pkg::*;

  logic [NREG-1:0][XLEN-1:0] val_q;
  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0][TAGW-1:0] tag_q;

  logic iss_hit;
  logic cmt_hit;
  logic cmt_clr;

  // Write qualifiers; x0 is never written so it stays zero
  always_comb begin
    iss_hit = iss_we && (iss_addr != '0);
    cmt_hit = cmt_we && (cmt_addr != '0);
    cmt_clr = cmt_hit && busy_q[cmt_addr] && (tag_q[cmt_addr] == cmt_tag);
  end

  // Committed values: written on every commit regardless of tag or flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= '0;
    end else if (cmt_hit) begin
      val_q[cmt_addr] <= cmt_data;
    end
  end

  // Busy/tag: flush beats issue, issue beats commit clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      tag_q  <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      // issue is assigned last so it overrides a same-register commit clear
      if (cmt_clr) begin
        busy_q[cmt_addr] <= 1'b0;
      end
      if (iss_hit) begin
        busy_q[iss_addr] <= 1'b1;
        tag_q[iss_addr]  <= iss_tag;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rport
    regfile_tagged_rport #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW),
      .TAGW (TAGW)
    ) u_rport (
      .rst      (rst),
      .en       (re[k]),
      .addr     (raddr[k*AW +: AW]),
      .vals     (val_q),
      .busy_vec (busy_q),
      .tag_vec  (tag_q),
      .cmt_we   (cmt_we),
      .cmt_addr (cmt_addr),
      .cmt_data (cmt_data),
      .cmt_tag  (cmt_tag),
      .data     (rdata[k*XLEN +: XLEN]),
      .busy     (rbusy[k]),
      .tag      (rtag[k*TAGW +: TAGW])
    );
  end

endmodule
